// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared scan states, display word layout and hex-to-segment table
package seg_scan_ctrl_pkg;
  localparam int NUM_DIGITS = 8;
  typedef enum logic {ST_BLANK, ST_SHOW} state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_t;
  localparam disp_t DISP_RST = '{data: 32'h0, dp: 8'h0, blank: 8'hFF};
  localparam logic [15:0][6:0] HEX7SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: per-digit slot counter with blank-end and slot-end strobes
module seg_slot_timer #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic blank_end,
  output logic slot_end
);
  localparam int W = $clog2(SLOT_CYC);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    blank_end = cnt_q == W'(BLANK_CYC - 1);
    slot_end  = cnt_q == W'(SLOT_CYC - 1);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-segment scanner with frame-synchronous double-buffered load
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_blank,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        frame_done
);
  state_e      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  disp_t       act_q, act_d, shd_q, shd_d;
  logic        ready_q, ready_d;
  logic [7:0]  an_q, an_d, seg_q, seg_d;
  logic [3:0]  nib;
  logic        show, blank_end, slot_end;
  seg_slot_timer #(.SLOT_CYC(SLOT_CYC), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk), .rst_n(rst_n), .blank_end(blank_end), .slot_end(slot_end)
  );
  // AN/SEG are registered from next-state values so they line up with state_q
  always_comb begin
    state_d    = slot_end ? ST_BLANK : blank_end ? ST_SHOW : state_q;
    digit_d    = slot_end ? digit_q + 3'd1 : digit_q;
    frame_done = slot_end && digit_q == 3'(NUM_DIGITS - 1);
    act_d      = (frame_done && !ready_q) ? shd_q : act_q;
    shd_d      = (ready_q && load_valid) ? {load_data, load_dp, load_blank} : shd_q;
    ready_d    = ready_q ? !load_valid : frame_done;
    nib        = act_d.data[{digit_d, 2'b00} +: 4];
    show       = state_d == ST_SHOW;
    an_d       = (show && !act_d.blank[digit_d]) ? ~(8'd1 << digit_d) : 8'hFF;
    seg_d      = show ? {~act_d.dp[digit_d], HEX7SEG[nib]} : 8'hFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_BLANK;
      digit_q <= '0;
      act_q   <= DISP_RST;
      shd_q   <= DISP_RST;
      ready_q <= 1'b1;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  assign load_ready = ready_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table-driven bench for seg_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2
module tb_seg_scan_ctrl;
  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0;
  logic        load_ready, frame_done;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0, load_blank = '0, AN, SEG;
  int          checks = 0, failures = 0;
  logic        exp_rdy = 1'b1, fd_prev = 1'b0;
  vec_t        tab[32];
  seg_scan_ctrl #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_blank(load_blank),
    .AN(AN), .SEG(SEG), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (exp_rdy && load_valid) exp_rdy = 1'b0;
    else if (!exp_rdy && fd_prev) exp_rdy = 1'b1;
    @(negedge clk);
    fd_prev = frame_done;
    chk("load_ready", {7'd0, load_ready}, {7'd0, exp_rdy});
    chk("an_onehot", {7'd0, $countones(~AN) <= 1}, 8'd1);
  endtask
  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (frame_done) return;
    end
    chk("wait_frame_done_timeout", 8'd0, 8'd1);
  endtask
  task automatic check_frame(input string tag, input int base, input int ld_at,
                             input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    for (int j = 0; j < 64; j++) begin
      cyc();
      if (j % 8 < 2) begin
        chk($sformatf("%s_blank_an_c%0d", tag, j), AN, 8'hFF);
        chk($sformatf("%s_blank_seg_c%0d", tag, j), SEG, 8'hFF);
      end else begin
        chk($sformatf("%s_an_c%0d", tag, j), AN, tab[base + j / 8].an);
        if (tab[base + j / 8].an != 8'hFF)
          chk($sformatf("%s_seg_c%0d", tag, j), SEG, tab[base + j / 8].seg);
      end
      chk($sformatf("%s_fd_c%0d", tag, j), {7'd0, frame_done}, {7'd0, j == 63});
      load_valid = j == ld_at;
      if (j == ld_at) begin
        load_data = d;
        load_dp = dp;
        load_blank = bl;
      end
    end
  endtask
  initial begin
    tab[0]  = '{8'hFE, 8'hC0}; tab[1]  = '{8'hFD, 8'hF9}; tab[2]  = '{8'hFB, 8'hA4}; tab[3]  = '{8'hF7, 8'hB0};
    tab[4]  = '{8'hEF, 8'h99}; tab[5]  = '{8'hDF, 8'h92}; tab[6]  = '{8'hBF, 8'h82}; tab[7]  = '{8'h7F, 8'hF8};
    tab[8]  = '{8'hFE, 8'h00}; tab[9]  = '{8'hFD, 8'h98}; tab[10] = '{8'hFB, 8'h88}; tab[11] = '{8'hF7, 8'h83};
    tab[12] = '{8'hEF, 8'hC6}; tab[13] = '{8'hDF, 8'hA1}; tab[14] = '{8'hBF, 8'h86}; tab[15] = '{8'h7F, 8'h8E};
    tab[16] = '{8'hFE, 8'hC0}; tab[17] = '{8'hFD, 8'hF9}; tab[18] = '{8'hFB, 8'hA4}; tab[19] = '{8'hF7, 8'hB0};
    for (int k = 20; k < 32; k++) tab[k] = '{8'hFF, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);
    chk("rst_ready", {7'd0, load_ready}, 8'd1);
    rst_n = 1'b1;
    load_valid = 1'b1;
    load_data = 32'h76543210;
    load_dp = 8'h00;
    load_blank = 8'h00;
    cyc();
    load_valid = 1'b0;
    wait_fd();
    check_frame("fA", 0, 20, 32'hFEDCBA98, 8'h01, 8'h00);
    check_frame("fB", 8, 63, 32'h76543210, 8'h00, 8'hF0);
    check_frame("fB2", 8, -1, '0, '0, '0);
    check_frame("fC", 16, -1, '0, '0, '0);
    repeat (12) cyc();
    load_valid = 1'b1;
    load_data = 32'hFEDCBA98;
    load_dp = 8'hFF;
    load_blank = 8'h00;
    cyc();
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", AN, 8'hFF);
    chk("async_rst_seg", SEG, 8'hFF);
    chk("async_rst_ready", {7'd0, load_ready}, 8'd1);
    chk("async_rst_fd", {7'd0, frame_done}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdy = 1'b1;
    fd_prev = 1'b0;
    wait_fd();
    check_frame("fD", 24, -1, '0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Parameters
REQ-001 The block SHALL have parameter SLOT_CYC, default 50000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, meaning cycles at slot start with all anodes off (ghost suppression); legal range 1..SLOT_CYC-1.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_valid, input, 1 bit: new display word offered.
REQ-006 The block SHALL have port load_ready, output, 1 bit: shadow register free.
REQ-007 The block SHALL have port load_data, input, 32 bits: eight hex nibbles; nibble k drives digit k.
REQ-008 The block SHALL have port load_dp, input, 8 bits: decimal point per digit, 1 = lit.
REQ-009 The block SHALL have port load_blank, input, 8 bits: 1 = digit k dark.
REQ-010 The block SHALL have port AN, output, 8 bits: anode enables, active-low, at most one bit low.
REQ-011 The block SHALL have port SEG, output, 8 bits: active-low; bit7 = DP, bits6:0 = g..a.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of digit-7 slot.

Function
REQ-013 Scan order SHALL be digit 0,1,...,7, then wrap to 0; each slot SHALL last exactly SLOT_CYC cycles.
REQ-014 The FSM SHALL have states BLANK and SHOW: BLANK for BLANK_CYC cycles (AN = 8'hFF), then SHOW for SLOT_CYC-BLANK_CYC cycles, then BLANK of the next digit.
REQ-015 In SHOW, AN SHALL equal ~(1<<digit) unless blank[digit]=1, in which case AN SHALL stay 8'hFF.
REQ-016 SEG SHALL be registered: {~dp[digit], hex7seg(nibble[digit])}; in BLANK, SEG SHALL be 8'hFF.
REQ-017 hex7seg for 0..F SHALL give bits6:0 of C0,F9,A4,B0,99,92,82,F8,80,98,88,83,C6,A1,86,8E.
REQ-018 A transfer SHALL occur on a clk edge with load_valid & load_ready; data, dp and blank SHALL be captured into a shadow register and load_ready SHALL go low the next cycle.
REQ-019 The shadow SHALL be copied to the active register only on the cycle frame_done is high; load_ready SHALL return high the following cycle (no mid-frame tearing).
REQ-020 A transfer coinciding with frame_done SHALL take effect at the NEXT frame boundary, not the current one.
REQ-021 Offers while load_ready=0 SHALL be ignored; load_valid SHALL NOT need to be held.
REQ-022 frame_done SHALL be high on the last cycle of the digit-7 slot regardless of blank mask.
REQ-023 Slot and digit counters SHALL wrap without skipping a count; digit counter is 3 bits.

Reset
REQ-024 rst_n low SHALL asynchronously force: AN=8'hFF, SEG=8'hFF, frame_done=0, load_ready=1, state=BLANK, digit=0, slot counter=0, active and shadow registers cleared (data 0, dp 0, blank 8'hFF).
REQ-025 After rst_n deasserts, the first BLANK slot of digit 0 SHALL begin on the next clk edge; reset mid-slot or mid-transfer SHALL discard the pending shadow.

Structure
REQ-026 A shared package SHALL hold the hex7seg 16-entry constant table, state encoding (BLANK, SHOW), and digit count (8).
REQ-027 One sub-module, seg_slot_timer (slot counter producing blank_end and slot_end strobes), SHALL be instantiated; the FSM and registers SHALL remain in seg_scan_ctrl.

Verification
REQ-028 SLOT_CYC=8, BLANK_CYC=2, load 32'h76543210, dp=0, blank=0 -> AN cycles FE..7F; during digit k SHOW, SEG = hex7seg(k) with bit7=1 (e.g. digit 2 -> 8'hA4).
REQ-029 Load 32'hFEDCBA98, dp=8'h01 mid-frame -> old value shown until frame_done; next frame digit 0 SEG=8'h00, digit 7 SEG=8'h8E; load_ready low then high after the boundary.
REQ-030 blank=8'hF0 -> AN never lower than 4'hF in the top nibble; frame_done period remains 64 cycles.
REQ-031 load_valid asserted on the frame_done cycle -> update takes effect one frame later (at 128 cycles, not 64).
REQ-032 rst_n pulsed low mid-SHOW with a pending load -> AN=SEG=8'hFF immediately (asynchronously), load_ready=1, and the pending value is never displayed.
REQ-033 Continuous checks on every cycle -> AN has at most one zero bit, and AN=8'hFF during every BLANK cycle.
